// File: rtl/regfile_mp_pkg.sv
// Shared constants, index/word types and the zero-register helper for regfile_mp.
// The zero register is always the highest index (ARM XZR style).
package regfile_pkg;

    localparam int XLEN      = 64;
    localparam int NREGS_DEF = 32;

    typedef logic [4:0]  reg_idx_t;
    typedef logic [63:0] word_t;

    function automatic int zero_reg(input int nregs);
        return nregs - 1;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Write, read and scoreboard bundle of regfile_mp; master is the pipeline, slave the register file.
// Read port k occupies rd_addr[k*AW +: AW], rd_data[k*WIDTH +: WIDTH] and rd_busy[k].
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int WIDTH = XLEN,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(NREGS);

    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [WIDTH-1:0]     wr_data;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*WIDTH-1:0] rd_data;
    logic [NRD-1:0]       rd_busy;
    logic                 sb_set;
    logic [AW-1:0]        sb_addr;
    logic                 any_busy;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, sb_set, sb_addr,
        input  rd_data, rd_busy, any_busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, sb_set, sb_addr,
        output rd_data, rd_busy, any_busy
    );

endinterface

// File: rtl/regfile_read_mux.sv
// NREGS:1 combinational mux of WIDTH-bit entries: 4:1 stages on index bit pairs (LSBs first),
// then a 2:1 stage on the top bit when the index width is odd. Zero latency.
module regfile_read_mux #(
    parameter int WIDTH = 64,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic [NREGS*WIDTH-1:0] din,
    input  logic [AW-1:0]          sel,
    output logic [WIDTH-1:0]       dout
);
    localparam int N4 = AW / 2;

    logic [WIDTH-1:0] cur [NREGS];

    // Each stage compacts groups of four in place; entry i is only overwritten
    // after its own group (4i..4i+3, all at or above i) has been consumed.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            cur[i] = din[i*WIDTH +: WIDTH];
        end
        for (int l = 0; l < N4; l++) begin
            for (int i = 0; i < NREGS / 4; i++) begin
                if (i < (NREGS >> (2 * (l + 1)))) begin
                    cur[i] = cur[4*i + int'(sel[2*l +: 2])];
                end
            end
        end
        if (AW % 2 == 1) begin
            cur[0] = sel[AW-1] ? cur[1] : cur[0];
        end
        dout = cur[0];
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: one synchronous write port, NRD combinational read ports, per-register
// pending-write scoreboard; top index reads as zero. Optional write-first forwarding: REGFILE_MP_BYPASS_EN.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH = XLEN,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2
) (
    input  logic       clk,
    input  logic       reset,
    regfile_mp_if.slave bus
);
    localparam int            AW = $clog2(NREGS);
    localparam logic [AW-1:0] ZR = AW'(zero_reg(NREGS));

    logic [WIDTH-1:0]       mem [NREGS-1];
    logic [NREGS-2:0]       sb;
    logic [NREGS*WIDTH-1:0] mem_flat;
    logic [NREGS-1:0]       sb_flat;

    // The loop never reaches ZR, so writes and sets aimed at it fall away.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS - 1; i++) begin
                mem[i] <= '0;
            end
            sb <= '0;
        end else begin
            for (int i = 0; i < NREGS - 1; i++) begin
                if (bus.wr_en && bus.wr_addr == AW'(i)) begin
                    mem[i] <= bus.wr_data;
                end
                // A newer producer issued this cycle outranks the completing one.
                if (bus.sb_set && bus.sb_addr == AW'(i)) begin
                    sb[i] <= 1'b1;
                end else if (bus.wr_en && bus.wr_addr == AW'(i)) begin
                    sb[i] <= 1'b0;
                end
            end
        end
    end

    for (genvar i = 0; i < NREGS - 1; i++) begin : g_flat
        assign mem_flat[i*WIDTH +: WIDTH] = mem[i];
    end
    assign mem_flat[NREGS*WIDTH-1 -: WIDTH] = '0;
    assign sb_flat = {1'b0, sb};

    for (genvar k = 0; k < NRD; k++) begin : g_port
        logic [AW-1:0]    ra;
        logic [WIDTH-1:0] mdat;
        logic             mbusy;
        logic             hit;

        assign ra = bus.rd_addr[k*AW +: AW];

        regfile_read_mux #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW)) u_dmux (
            .din  (mem_flat),
            .sel  (ra),
            .dout (mdat)
        );

        regfile_read_mux #(.WIDTH(1), .NREGS(NREGS), .AW(AW)) u_bmux (
            .din  (sb_flat),
            .sel  (ra),
            .dout (mbusy)
        );

`ifdef REGFILE_MP_BYPASS_EN
        assign hit = bus.wr_en && (bus.wr_addr == ra) && (ra != ZR);
`else
        assign hit = 1'b0;
`endif

        assign bus.rd_data[k*WIDTH +: WIDTH] = reset ? '0 : (hit ? bus.wr_data : mdat);
        assign bus.rd_busy[k]                = reset ? 1'b0 : (hit ? 1'b0 : mbusy);
    end

    assign bus.any_busy = reset ? 1'b0 : |sb;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed scenarios on the default configuration, then a randomized sweep of a 32-bit/16-reg/3-port
// instance against an array-based reference model.
module tb_regfile_mp;
    import regfile_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    regfile_mp_if #(.WIDTH(64), .NREGS(32), .NRD(2)) bus ();
    regfile_mp_if #(.WIDTH(32), .NREGS(16), .NRD(3)) bus2 ();

    regfile_mp #(.WIDTH(64), .NREGS(32), .NRD(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    regfile_mp #(.WIDTH(32), .NREGS(16), .NRD(3)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.slave)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
        else n_pass++;
    endtask

    task automatic idle_inputs();
        bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.sb_set = 0; bus.sb_addr = '0; bus.rd_addr = '0;
        bus2.wr_en = 0; bus2.wr_addr = '0; bus2.wr_data = '0;
        bus2.sb_set = 0; bus2.sb_addr = '0; bus2.rd_addr = '0;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        bus.rd_addr = {5'd3, 5'd0};
        #2;
        chk("reset_rd0", bus.rd_data[63:0], 64'd0);
        chk("reset_rd1", bus.rd_data[127:64], 64'd0);
        chk("reset_busy", {62'd0, bus.rd_busy}, 64'd0);
        chk("reset_any", {63'd0, bus.any_busy}, 64'd0);
        edge_step();
        reset = 1'b0;
        edge_step();
        bus.wr_en = 1; bus.wr_addr = 5'd3; bus.wr_data = 64'hDEAD;
        bus.sb_set = 1; bus.sb_addr = 5'd4;
        edge_step();
        bus.wr_en = 0; bus.sb_set = 0;
        bus.rd_addr = {5'd4, 5'd3};
        #1;
        if (bus.rd_data[63:0] !== 64'hDEAD) begin
            n_total++; $display("FAIL pre_reset_x3: got %h expected %h", bus.rd_data[63:0], 64'hDEAD);
        end else begin
            n_total++; n_pass++;
        end
        chk("pre_reset_any", {63'd0, bus.any_busy}, 64'd1);
        reset = 1'b1;
        #1;
        chk("midrst_rd0", bus.rd_data[63:0], 64'd0);
        chk("midrst_any", {63'd0, bus.any_busy}, 64'd0);
        chk("midrst_busy", {62'd0, bus.rd_busy}, 64'd0);
        edge_step();
        reset = 1'b0;
        #1;
        chk("post_rst_x3", bus.rd_data[63:0], 64'd0);
    endtask

    task automatic test_basic();
        bus.wr_en = 1; bus.wr_addr = 5'd5; bus.wr_data = 64'h0123_4567_89AB_CDEF;
        edge_step();
        bus.wr_en = 0;
        bus.rd_addr = {5'd5, 5'd5};
        #1;
        chk("basic_p0", bus.rd_data[63:0], 64'h0123_4567_89AB_CDEF);
        chk("basic_p1", bus.rd_data[127:64], 64'h0123_4567_89AB_CDEF);
    endtask

    task automatic test_zero();
        bus.wr_en = 1; bus.wr_addr = 5'd31; bus.wr_data = '1;
        bus.sb_set = 1; bus.sb_addr = 5'd31;
        bus.rd_addr = {5'd31, 5'd31};
        edge_step();
        bus.wr_en = 0; bus.sb_set = 0;
        #1;
        chk("zero_p0", bus.rd_data[63:0], 64'd0);
        chk("zero_p1", bus.rd_data[127:64], 64'd0);
        chk("zero_busy", {62'd0, bus.rd_busy}, 64'd0);
        chk("zero_any", {63'd0, bus.any_busy}, 64'd0);
    endtask

    task automatic test_scoreboard();
        bus.rd_addr = {5'd9, 5'd7};
        bus.sb_set = 1; bus.sb_addr = 5'd7;
        #1;
        chk("sb_before_set", {63'd0, bus.rd_busy[0]}, 64'd0);
        edge_step();
        bus.sb_set = 0;
        #1;
        chk("sb_x7_set", {63'd0, bus.rd_busy[0]}, 64'd1);
        chk("sb_any_set", {63'd0, bus.any_busy}, 64'd1);
        edge_step();
        edge_step();
        chk("sb_x7_held", {63'd0, bus.rd_busy[0]}, 64'd1);
        bus.wr_en = 1; bus.wr_addr = 5'd7; bus.wr_data = 64'h77;
        edge_step();
        bus.wr_en = 0;
        #1;
        chk("sb_x7_clr", {63'd0, bus.rd_busy[0]}, 64'd0);
        chk("sb_any_clr", {63'd0, bus.any_busy}, 64'd0);
        bus.sb_set = 1; bus.sb_addr = 5'd9;
        bus.wr_en = 1; bus.wr_addr = 5'd9; bus.wr_data = 64'h99;
        edge_step();
        bus.sb_set = 0; bus.wr_en = 0;
        #1;
        chk("sb_x9_set_wins", {63'd0, bus.rd_busy[1]}, 64'd1);
        bus.wr_en = 1; bus.wr_addr = 5'd9;
        edge_step();
        bus.wr_en = 0;
        #1;
        chk("sb_x9_clr", {63'd0, bus.rd_busy[1]}, 64'd0);
    endtask

    task automatic test_same_cycle();
        bus.wr_en = 1; bus.wr_addr = 5'd10; bus.wr_data = 64'h11;
        bus.sb_set = 1; bus.sb_addr = 5'd10;
        edge_step();
        bus.sb_set = 0;
        bus.wr_data = 64'h22;
        bus.rd_addr = {5'd10, 5'd10};
        #1;
`ifdef REGFILE_MP_BYPASS_EN
        chk("same_cyc_data", bus.rd_data[63:0], 64'h22);
        chk("same_cyc_busy", {63'd0, bus.rd_busy[0]}, 64'd0);
`else
        chk("same_cyc_data", bus.rd_data[63:0], 64'h11);
        chk("same_cyc_busy", {63'd0, bus.rd_busy[0]}, 64'd1);
`endif
        edge_step();
        bus.wr_en = 0;
        #1;
        chk("after_wr_data", bus.rd_data[127:64], 64'h22);
        chk("after_wr_busy", {63'd0, bus.rd_busy[1]}, 64'd0);
    endtask

    task automatic test_random_sweep();
        logic [31:0] m_mem [16];
        bit          m_sb  [16];
        logic [3:0]  ra    [3];
        logic [3:0]  wa, sa;
        logic [31:0] wd, exp_d;
        bit          we, ss, exp_b, exp_any, byp;
        for (int i = 0; i < 16; i++) begin
            m_mem[i] = 0;
            m_sb[i]  = 0;
        end
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            we = 1'($urandom_range(0, 1));
            wa = 4'($urandom_range(0, 15));
            wd = $urandom;
            ss = ($urandom_range(0, 3) == 0);
            sa = 4'($urandom_range(0, 15));
            for (int k = 0; k < 3; k++) begin
                ra[k] = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
            end
            bus2.wr_en = we; bus2.wr_addr = wa; bus2.wr_data = wd;
            bus2.sb_set = ss; bus2.sb_addr = sa;
            bus2.rd_addr = {ra[2], ra[1], ra[0]};
            #1;
            for (int k = 0; k < 3; k++) begin
`ifdef REGFILE_MP_BYPASS_EN
                byp = we && (wa == ra[k]) && (ra[k] != 4'd15);
`else
                byp = 1'b0;
`endif
                if (ra[k] == 4'd15) begin
                    exp_d = 0; exp_b = 0;
                end else if (byp) begin
                    exp_d = wd; exp_b = 0;
                end else begin
                    exp_d = m_mem[ra[k]]; exp_b = m_sb[ra[k]];
                end
                n_total++;
                if (bus2.rd_data[k*32 +: 32] !== exp_d)
                    $display("FAIL sweep_data c=%0d port=%0d: got %h expected %h", c, k, bus2.rd_data[k*32 +: 32], exp_d);
                else n_pass++;
                n_total++;
                if (bus2.rd_busy[k] !== exp_b)
                    $display("FAIL sweep_busy c=%0d port=%0d: got %b expected %b", c, k, bus2.rd_busy[k], exp_b);
                else n_pass++;
            end
            exp_any = 0;
            for (int i = 0; i < 16; i++) exp_any = exp_any | m_sb[i];
            n_total++;
            if (bus2.any_busy !== exp_any)
                $display("FAIL sweep_any c=%0d: got %b expected %b", c, bus2.any_busy, exp_any);
            else n_pass++;
            @(posedge clk);
            if (we && wa != 4'd15) m_mem[wa] = wd;
            if (we) m_sb[wa] = 0;
            if (ss && sa != 4'd15) m_sb[sa] = 1;
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_scoreboard();
        test_same_cycle();
        test_random_sweep();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
